// File: rtl/fifo_bist_ctrl.sv
// Built-in self-test controller for a single-clock width-converting FIFO: writes a
// decrementing pattern, reads it back slice by slice and counts data and flag errors.
module fifo_bist_ctrl #(
    parameter int WR_DATA_WIDTH  = 128,
    parameter int RD_DATA_WIDTH  = 32,
    parameter int WR_DEPTH_WIDTH = 10,
    parameter int RD_LATENCY     = 1,
    parameter int MODE           = 0,
    parameter int ERR_W          = 4
) (
    input  logic                     clk,
    input  logic                     tb_rst,
    input  logic                     start,
    output logic [WR_DATA_WIDTH-1:0] fifo_wr_data,
    output logic                     fifo_wr_en,
    input  logic                     fifo_wr_full,
    output logic                     fifo_rd_en,
    input  logic [RD_DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                     fifo_rd_empty,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [ERR_W-1:0]         err_cnt
);
    localparam int RATIO   = WR_DATA_WIDTH / RD_DATA_WIDTH;
    localparam int RATIO_L = $clog2(RATIO);
    localparam int WC_W    = WR_DEPTH_WIDTH + 1;
    localparam int RC_W    = WR_DEPTH_WIDTH + RATIO_L + 1;
    localparam int GAP_CYC = 4;

    localparam logic [WC_W-1:0] NW = WC_W'(1) << WR_DEPTH_WIDTH;
    localparam logic [RC_W-1:0] NR = RC_W'(1) << (WR_DEPTH_WIDTH + RATIO_L);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_RUN   = 3'd4;
    localparam logic [2:0] S_FLUSH = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]               state;
    logic [WC_W-1:0]          wr_cnt;
    logic [RC_W-1:0]          rd_cnt;
    logic [3:0]               cyc_cnt;
    logic [WR_DATA_WIDTH-1:0] wr_pat;

    logic                     wr_phase;
    logic                     rd_phase;
    logic                     wr_acc;
    logic                     rd_acc;
    logic                     wr_fin;
    logic                     rd_fin;
    logic                     gap_end;
    logic                     flush_end;
    logic                     gap_err;
    logic                     flush_err;
    logic                     mism;
    logic [1:0]               err_inc;

    logic [RD_LATENCY-1:0]    vld_p;
    logic [RD_DATA_WIDTH-1:0] exp_p [RD_LATENCY];

    // Expected read k: slice (k mod RATIO) of pattern word ~k/RATIO, LSB slice first.
    function automatic logic [RD_DATA_WIDTH-1:0] rd_expect(input logic [RC_W-1:0] k);
        logic [WR_DATA_WIDTH-1:0] word;
        logic [RC_W-1:0]          slice;
        word  = ~WR_DATA_WIDTH'(k >> RATIO_L);
        slice = k & RC_W'(RATIO - 1);
        return RD_DATA_WIDTH'(word >> (int'(slice) * RD_DATA_WIDTH));
    endfunction

    function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] a,
                                                 input logic [1:0]       inc);
        logic [ERR_W:0] s;
        s = {1'b0, a} + (ERR_W + 1)'(inc);
        return s[ERR_W] ? '1 : s[ERR_W-1:0];
    endfunction

    assign wr_phase     = (state == S_WRITE) || ((state == S_RUN) && (wr_cnt != NW));
    assign rd_phase     = (state == S_READ)  || ((state == S_RUN) && (rd_cnt != NR));
    assign fifo_wr_en   = wr_phase && !fifo_wr_full;
    assign fifo_rd_en   = rd_phase && !fifo_rd_empty;
    assign fifo_wr_data = wr_phase ? wr_pat : '0;
    assign wr_acc       = fifo_wr_en;
    assign rd_acc       = fifo_rd_en;

    assign wr_fin = (wr_cnt == NW) || (wr_acc && (wr_cnt == NW - WC_W'(1)));
    assign rd_fin = (rd_cnt == NR) || (rd_acc && (rd_cnt == NR - RC_W'(1)));

    assign gap_end   = (state == S_GAP)   && (cyc_cnt == 4'(GAP_CYC - 1));
    assign flush_end = (state == S_FLUSH) && (cyc_cnt == 4'(RD_LATENCY - 1));
    assign gap_err   = (MODE == 0) && gap_end   && !fifo_wr_full;
    assign flush_err = (MODE == 0) && flush_end && !fifo_rd_empty;
    assign mism      = vld_p[RD_LATENCY-1] && (fifo_rd_data != exp_p[RD_LATENCY-1]);
    assign err_inc   = 2'(mism) + 2'(gap_err) + 2'(flush_err);

    assign busy = (state != S_IDLE) && (state != S_DONE);
    assign done = (state == S_DONE);
    assign pass = done && (err_cnt == '0);

    // Read check pipeline: p0 holds the accepted read, last stage lines up with fifo_rd_data
    always_ff @(posedge clk) begin
        exp_p[0] <= rd_expect(rd_cnt);
        for (int i = 1; i < RD_LATENCY; i++) begin
            exp_p[i] <= exp_p[i-1];
        end
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= rd_acc;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            state   <= S_IDLE;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            cyc_cnt <= '0;
            wr_pat  <= '1;
            err_cnt <= '0;
        end else begin
            err_cnt <= sat_add(err_cnt, err_inc);
            if (wr_acc) begin
                wr_cnt <= wr_cnt + WC_W'(1);
                wr_pat <= wr_pat - WR_DATA_WIDTH'(1);
            end
            if (rd_acc) begin
                rd_cnt <= rd_cnt + RC_W'(1);
            end
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state   <= (MODE != 0) ? S_RUN : S_WRITE;
                        wr_cnt  <= '0;
                        rd_cnt  <= '0;
                        cyc_cnt <= '0;
                        wr_pat  <= '1;
                        err_cnt <= '0;
                    end
                end
                S_WRITE: begin
                    if (wr_fin) begin
                        state   <= S_GAP;
                        cyc_cnt <= '0;
                    end
                end
                S_GAP: begin
                    if (gap_end) begin
                        state   <= S_READ;
                        cyc_cnt <= '0;
                    end else begin
                        cyc_cnt <= cyc_cnt + 4'd1;
                    end
                end
                S_READ: begin
                    if (rd_fin) begin
                        state   <= S_FLUSH;
                        cyc_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (wr_fin && rd_fin) begin
                        state   <= S_FLUSH;
                        cyc_cnt <= '0;
                    end
                end
                S_FLUSH: begin
                    if (flush_end) begin
                        state <= S_DONE;
                    end else begin
                        cyc_cnt <= cyc_cnt + 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_bist_ctrl.sv
// Bench for fifo_bist_ctrl: three configurations driven against a queue-style FIFO model
// with injectable data corruption, stuck flags and random empty stalls.
module tb_fifo_bist_ctrl;
    localparam int NW = 1024;

    logic clk = 1'b0;
    logic tb_rst;
    logic [2:0] start_r;
    logic [2:0] clr_r;
    logic [2:0] stuck_ne;
    logic [2:0] no_full;
    int flip_k [3];
    int corrupt_n [3];
    int stall_pct [3];

    wire [2:0] busy_a, done_a, pass_a, wen_a, ren_a;
    wire [3:0]   err_a [3];
    wire [127:0] wd_a [3];
    wire [127:0] fw_a [3];
    wire [127:0] lw_a [3];
    wire [31:0]  nwr_a [3];
    wire [31:0]  nrd_a [3];
    wire [31:0]  nbad_a [3];
    wire [31:0]  ncor_a [3];
    wire [31:0]  nviol_a [3];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Instance 0: defaults, 1: concurrent mode, 2: 32->32 with output register
    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int WRW = (g == 2) ? 32 : 128;
        localparam int RDW = 32;
        localparam int LAT = (g == 2) ? 2 : 1;
        localparam int MD  = (g == 1) ? 1 : 0;
        localparam int RAT = WRW / RDW;
        localparam int CAP = NW * RAT;

        logic [WRW-1:0] wdata;
        logic [RDW-1:0] rdata, rstage, rq;
        logic [RDW-1:0] mem [CAP];
        logic           wfull, rempty, stall, cor;
        logic [WRW-1:0] ew;
        logic [127:0]   fw, lw;
        int wp, rp, nwr, nrd, nbad, ncor, nviol;

        fifo_bist_ctrl #(
            .WR_DATA_WIDTH(WRW), .RD_DATA_WIDTH(RDW), .WR_DEPTH_WIDTH(10),
            .RD_LATENCY(LAT), .MODE(MD), .ERR_W(4)
        ) u_dut (
            .clk(clk), .tb_rst(tb_rst), .start(start_r[g]),
            .fifo_wr_data(wdata), .fifo_wr_en(wen_a[g]), .fifo_wr_full(wfull),
            .fifo_rd_en(ren_a[g]), .fifo_rd_data(rdata), .fifo_rd_empty(rempty),
            .busy(busy_a[g]), .done(done_a[g]), .pass(pass_a[g]), .err_cnt(err_a[g])
        );

        assign wfull  = !no_full[g] && ((wp - rp) > (CAP - RAT));
        assign rempty = ((wp == rp) && !stuck_ne[g]) || stall;
        assign rdata  = (LAT == 2) ? rq : rstage;

        assign wd_a[g]    = 128'(wdata);
        assign fw_a[g]    = fw;
        assign lw_a[g]    = lw;
        assign nwr_a[g]   = 32'(nwr);
        assign nrd_a[g]   = 32'(nrd);
        assign nbad_a[g]  = 32'(nbad);
        assign ncor_a[g]  = 32'(ncor);
        assign nviol_a[g] = 32'(nviol);

        always @(posedge clk) begin
            if (tb_rst || clr_r[g]) begin
                wp <= 0; rp <= 0; nwr <= 0; nrd <= 0;
                nbad <= 0; ncor <= 0; nviol <= 0;
                stall <= 1'b0; fw <= '0; lw <= '0;
                rstage <= '0; rq <= '0;
            end else begin
                stall <= ($urandom_range(0, 99) < 32'(stall_pct[g]));
                rq    <= rstage;
                if ((wen_a[g] && wfull) || (ren_a[g] && rempty)) nviol <= nviol + 1;
                if (wen_a[g] && !wfull) begin
                    for (int s = 0; s < RAT; s++) mem[(wp + s) % CAP] <= wdata[s*RDW +: RDW];
                    wp <= wp + RAT;
                    ew = '1;
                    ew = ew - WRW'(nwr);
                    if (wdata != ew) nbad <= nbad + 1;
                    if (nwr == 0) fw <= 128'(wdata);
                    lw  <= 128'(wdata);
                    nwr <= nwr + 1;
                end
                if (ren_a[g] && !rempty) begin
                    cor = (nrd == flip_k[g]) || (nrd < corrupt_n[g]);
                    rstage <= mem[rp % CAP] ^ RDW'(cor);
                    if (cor) ncor <= ncor + 1;
                    rp  <= rp + 1;
                    nrd <= nrd + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic knobs(input int g, input int fk, input int cn, input bit sne,
                         input bit nf, input int sp);
        flip_k[g] = fk; corrupt_n[g] = cn; stuck_ne[g] = sne;
        no_full[g] = nf; stall_pct[g] = sp;
    endtask

    task automatic launch(input int g);
        @(negedge clk); clr_r[g] = 1'b1;
        @(negedge clk); clr_r[g] = 1'b0; start_r[g] = 1'b1;
        @(negedge clk); start_r[g] = 1'b0;
    endtask

    task automatic outputs_zero(input int g, input string name);
        check({name, "_busy"}, 128'(busy_a[g]), 128'(0));
        check({name, "_done"}, 128'(done_a[g]), 128'(0));
        check({name, "_pass"}, 128'(pass_a[g]), 128'(0));
        check({name, "_err"},  128'(err_a[g]),  128'(0));
        check({name, "_wen"},  128'(wen_a[g]),  128'(0));
        check({name, "_ren"},  128'(ren_a[g]),  128'(0));
        check({name, "_wdat"}, wd_a[g], 128'(0));
    endtask

    // Wait for done, then compare the run against what the injected faults imply
    task automatic finish_check(input int g, input string name, input int flag_exp);
        int cyc;
        int rat;
        int exp_err;
        logic [127:0] ones;
        cyc = 0;
        while (!done_a[g] && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_finished"}, 128'(done_a[g]), 128'(1));
        rat  = (g == 2) ? 1 : 4;
        ones = (g == 2) ? 128'(32'hFFFF_FFFF) : '1;
        exp_err = int'(ncor_a[g]) + flag_exp;
        if (exp_err > 15) exp_err = 15;
        check({name, "_writes"}, 128'(nwr_a[g]), 128'(NW));
        check({name, "_reads"},  128'(nrd_a[g]), 128'(NW * rat));
        check({name, "_wpat"},   128'(nbad_a[g]), 128'(0));
        check({name, "_first"},  fw_a[g], ones);
        check({name, "_last"},   lw_a[g], ones - 128'(NW - 1));
        check({name, "_viol"},   128'(nviol_a[g]), 128'(0));
        check({name, "_err"},    128'(err_a[g]), 128'(exp_err));
        check({name, "_pass"},   128'(pass_a[g]), 128'(exp_err == 0));
        check({name, "_busy"},   128'(busy_a[g]), 128'(0));
    endtask

    task automatic reset_mid(input int g, input string name);
        int cyc;
        knobs(g, -1, 0, 1'b0, 1'b0, 0);
        launch(g);
        cyc = 0;
        while (nwr_a[g] < 300 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_reach300"}, 128'(nwr_a[g] >= 300), 128'(1));
        tb_rst = 1'b1;
        #1;
        outputs_zero(g, {name, "_rst0"});
        @(negedge clk);
        @(negedge clk);
        outputs_zero(g, {name, "_rst2"});
        tb_rst = 1'b0;
        launch(g);
        finish_check(g, {name, "_rerun"}, 0);
    endtask

    initial begin
        tb_rst = 1'b1;
        start_r = '0; clr_r = '0;
        for (int g = 0; g < 3; g++) knobs(g, -1, 0, 1'b0, 1'b0, 0);
        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) outputs_zero(g, $sformatf("reset%0d", g));
        tb_rst = 1'b0;
        @(negedge clk);

        launch(0); finish_check(0, "clean", 0);
        knobs(0, 5, 0, 1'b0, 1'b0, 0);
        launch(0); finish_check(0, "flip5", 0);
        knobs(0, -1, 20, 1'b0, 1'b0, 0);
        launch(0); finish_check(0, "sat20", 0);
        knobs(0, -1, 0, 1'b1, 1'b0, 0);
        launch(0); finish_check(0, "stuck_ne", 1);
        knobs(0, -1, 0, 1'b0, 1'b1, 0);
        launch(0); finish_check(0, "no_full", 1);
        knobs(0, -1, 0, 1'b0, 1'b0, 0);
        launch(0); finish_check(0, "clean2", 0);

        knobs(1, -1, 0, 1'b0, 1'b0, 30);
        launch(1); finish_check(1, "conc_stall", 0);
        knobs(1, 7, 0, 1'b0, 1'b0, 30);
        launch(1); finish_check(1, "conc_flip", 0);

        reset_mid(0, "rstmid");

        knobs(2, -1, 0, 1'b0, 1'b0, 0);
        launch(2); finish_check(2, "r1_clean", 0);
        knobs(2, 100, 0, 1'b0, 1'b0, 0);
        launch(2); finish_check(2, "r1_flip", 0);
        reset_mid(2, "r1_rstmid");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
